// File: rtl/rr_demux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_demux_pkg
// Brief    : Shared types and sizes for the round-robin demux arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_demux_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_demux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_demux_arbiter_if
// Brief    : Request/grant bundle between requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_demux_arbiter_if;
    import rr_demux_pkg::*;

    logic     en;
    req_vec_t req;
    req_vec_t grant;
    idx_t     grant_idx;
    logic     grant_valid;
    logic     preempt;

    modport master (
        output en,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  en,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output preempt
    );

endinterface
`default_nettype wire

// File: rtl/rr_demux_arbiter_pick8.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick8
// Brief    : Cyclic first-set-bit finder starting at a pointer position.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick8
    import rr_demux_pkg::*;
(
    input  req_vec_t i_cand,
    input  idx_t     i_ptr,
    output logic     o_found,
    output idx_t     o_idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    req_vec_t             w_rot;
    idx_t                 w_off;

    // Rotate so the pointer position lands on bit 0, then encode the lowest set bit.
    assign w_dbl = {i_cand, i_cand} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = idx_t'(i);
            end
        end
    end

    assign o_found = |i_cand;
    assign o_idx   = i_ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/rr_demux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_demux_arbiter
// Brief    : 8-way round-robin arbiter with grant hold, hold-time preemption
//            and a registered one-hot grant for demux channel enables.
// Revision : 1.0 - initial release
// ============================================================================
module rr_demux_arbiter
    import rr_demux_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst,
    rr_demux_arbiter_if.slave  bus
);

    localparam bit               c_HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] c_HOLD_LAST    = (MAX_HOLD < 1) ? '0 : CNT_W'(MAX_HOLD - 1);

    arb_state_t       r_state;
    idx_t             r_idx;
    idx_t             r_ptr;
    logic             r_valid;
    logic             r_preempt;
    logic [CNT_W-1:0] r_hold_cnt;

    req_vec_t w_cur_mask;
    req_vec_t w_cand;
    idx_t     w_pick_ptr;
    logic     w_found;
    idx_t     w_pick_idx;
    logic     w_holding;
    logic     w_timeout;

    // While granted, the holder is masked out and the scan starts just past it;
    // on release the holder's bit is already clear so the same path serves both.
    assign w_cur_mask = req_vec_t'(1) << r_idx;
    assign w_cand     = (r_state == GRANT) ? (bus.req & ~w_cur_mask) : bus.req;
    assign w_pick_ptr = (r_state == GRANT) ? (r_idx + idx_t'(1)) : r_ptr;
    assign w_holding  = bus.req[r_idx];
    assign w_timeout  = c_HOLD_LIMITED && (r_hold_cnt == c_HOLD_LAST);

    rr_pick8 u_pick (
        .i_cand  (w_cand),
        .i_ptr   (w_pick_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_valid    <= 1'b0;
            r_preempt  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.en && w_found) begin
                        r_state    <= GRANT;
                        r_idx      <= w_pick_idx;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!w_holding) begin
                        r_ptr <= w_pick_ptr;
                        if (bus.en && w_found) begin
                            r_idx      <= w_pick_idx;
                            r_hold_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        // A sole (or enable-blocked) holder is re-granted in place.
                        r_preempt  <= 1'b1;
                        r_ptr      <= w_pick_ptr;
                        r_hold_cnt <= '0;
                        if (bus.en && w_found) begin
                            r_idx <= w_pick_idx;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = r_valid ? w_cur_mask : '0;
    assign bus.grant_idx   = r_idx;
    assign bus.grant_valid = r_valid;
    assign bus.preempt     = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_demux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_demux_arbiter
// Brief    : Directed and randomized self-checking bench for rr_demux_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_demux_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_demux_arbiter_if bus ();

    rr_demux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_cnt;
    bit m_pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] v, input int p);
        for (int k = 0; k < 8; k++) begin
            if (v[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    // Reference arbiter: one call per rising edge, using the inputs the DUT sampled.
    task automatic model_step();
        logic [7:0] others;
        if (rst) begin
            m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (!m_valid) begin
                if (bus.en && bus.req != 8'h00) begin
                    m_idx = pick(bus.req, m_ptr); m_valid = 1'b1; m_cnt = 0;
                end
            end else if (!bus.req[m_idx]) begin
                m_ptr = (m_idx + 1) % 8;
                if (bus.en && bus.req != 8'h00) begin
                    m_idx = pick(bus.req, m_ptr); m_cnt = 0;
                end else begin
                    m_valid = 1'b0; m_idx = 0;
                end
            end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1) begin
                m_pre  = 1'b1;
                m_ptr  = (m_idx + 1) % 8;
                others = bus.req;
                others[m_idx] = 1'b0;
                if (bus.en && others != 8'h00) m_idx = pick(others, m_ptr);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic cycle();
        int exp_grant;
        @(posedge clk);
        model_step();
        #1;
        exp_grant = m_valid ? (1 << m_idx) : 0;
        check("grant",       32'(bus.grant),       32'(exp_grant));
        check("grant_idx",   32'(bus.grant_idx),   32'(m_idx));
        check("grant_valid", 32'(bus.grant_valid), 32'(m_valid));
        check("preempt",     32'(bus.preempt),     32'(m_pre));
    endtask

    initial begin
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        rst     = 1'b1;
        m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_pre = 1'b0;

        repeat (2) begin
            cycle();
            check("rst_grant", 32'(bus.grant), 32'h0);
            check("rst_valid", 32'(bus.grant_valid), 32'h0);
        end
        rst = 1'b0; bus.req = 8'h00;
        repeat (2) begin
            cycle();
            check("idle_grant", 32'(bus.grant), 32'h0);
        end

        bus.req = 8'h05; cycle();
        check("basic_grant", 32'(bus.grant), 32'h01);
        check("basic_idx", 32'(bus.grant_idx), 32'd0);
        bus.req = 8'h04; cycle();
        check("handoff_grant", 32'(bus.grant), 32'h04);
        check("handoff_idx", 32'(bus.grant_idx), 32'd2);
        bus.req = 8'h00; cycle();
        check("release_grant", 32'(bus.grant), 32'h0);

        bus.req = 8'h80; cycle();
        check("wrap_hold7", 32'(bus.grant), 32'h80);
        bus.req = 8'h03; cycle();
        check("wrap_grant", 32'(bus.grant), 32'h01);
        bus.req = 8'h00; cycle();
        bus.req = 8'h03; cycle();
        check("wrap_idx1_first", 32'(bus.grant_idx), 32'd1);
        bus.req = 8'h00; cycle();

        rst = 1'b1; cycle(); rst = 1'b0;
        bus.req = 8'h28;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("pre_grant", 32'(bus.grant), (k >= 5 && k <= 8) ? 32'h20 : 32'h08);
            check("pre_pulse", 32'(bus.preempt), (k == 5 || k == 9) ? 32'h1 : 32'h0);
        end
        bus.req = 8'h00; cycle();

        rst = 1'b1; cycle(); rst = 1'b0;
        bus.req = 8'h80;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("sole_grant", 32'(bus.grant), 32'h80);
            check("sole_pulse", 32'(bus.preempt), (k == 5 || k == 9) ? 32'h1 : 32'h0);
        end
        bus.req = 8'h00; cycle();

        bus.en = 1'b0; bus.req = 8'h10;
        repeat (2) begin
            cycle();
            check("en_off_grant", 32'(bus.grant), 32'h0);
        end
        bus.en = 1'b1; cycle();
        check("en_on_grant", 32'(bus.grant), 32'h10);
        rst = 1'b1; cycle();
        check("midrst_grant", 32'(bus.grant), 32'h0);
        check("midrst_valid", 32'(bus.grant_valid), 32'h0);
        check("midrst_idx", 32'(bus.grant_idx), 32'h0);
        rst = 1'b0; bus.req = 8'h11; cycle();
        check("postrst_grant", 32'(bus.grant), 32'h01);
        check("postrst_idx", 32'(bus.grant_idx), 32'd0);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(3, 0) == 0) bus.req = 8'($urandom) & 8'($urandom);
            bus.en = ($urandom_range(7, 0) != 0);
            rst    = ($urandom_range(63, 0) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_demux_arbiter.md
Name: rr_demux_arbiter

Overview:
- Round-robin arbiter that shares one 8-way demultiplexed resource among 8 requesters.
- Produces a registered 3-bit grant index and its one-hot 8-bit decode; the one-hot grant drives the per-channel enables of the demux.
- Supports grant hold with release handoff, a hold-time preemption limit and a global enable.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one requester may hold the grant while others wait; 0 = unlimited.
- CNT_W, $clog2(MAX_HOLD+1) (minimum 1), width of the hold counter (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- en  input  1  arbitration enable; new grants are issued only when high.
- req  input  8  request vector, bit i = requester i.
- grant  output  8  one-hot grant, or 0 when idle; registered.
- grant_idx  output  3  index of the granted requester; registered; 0 when idle.
- grant_valid  output  1  high when grant is nonzero; registered.
- preempt  output  1  one-cycle pulse when the current grant is forcibly ended by MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE; grant=0, grant_idx=0, grant_valid=0, preempt=0.
  - Priority pointer ptr=0; hold_cnt=0.
  - Applies at the next edge even mid-grant.
- FSM has two states, IDLE and GRANT.
- Pick function: the first set bit of a candidate vector, scanning cyclically from ptr upward (7 wraps to 0).
- IDLE:
  - If en=1 and req!=0, the winner is picked and the FSM enters GRANT.
  - Outputs reflect the winner on the following cycle (1-cycle latency req→grant).
  - Otherwise the FSM stays in IDLE with outputs 0.
- GRANT, current index g:
  - Hold: req[g]=1 and the hold limit is not reached → grant unchanged, hold_cnt++.
  - Release: req[g]=0.
    - ptr <= g+1 mod 8.
    - If en=1 and another req bit is set, the grant switches directly to the pick from ptr=g+1 on the next cycle (no idle bubble) and hold_cnt resets to 0.
    - Otherwise go to IDLE and outputs clear next cycle.
  - Timeout: MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 while req[g]=1.
    - preempt=1 for exactly one cycle, coincident with the new grant appearing; ptr <= g+1 mod 8.
    - Candidates are req with bit g masked. If any remain and en=1, grant the pick.
    - If g is the sole requester (or en=0 with other requesters), g is re-granted with hold_cnt=0; preempt still pulses.
- en=0 during GRANT:
  - The current holder keeps the grant until release or timeout.
  - Release then returns to IDLE with no handoff.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == (grant != 0).
  - grant == 8'b1 << grant_idx whenever grant_valid.
  - A requester that deasserts req loses the grant the next cycle.
- X on req while rst=1 is ignored.

Decomposition:
- Package rr_demux_pkg:
  - NUM_REQ=8 and IDX_W=3.
  - typedef req_vec_t (logic [7:0]) and idx_t (logic [2:0]).
  - enum arb_state_t {IDLE, GRANT}.
- Sub-module rr_pick8 (combinational):
  - Inputs: candidate vector, ptr.
  - Outputs: found flag and 3-bit winner index.
  - Implemented as a rotate + priority encode + rotate back.
- One-hot decode of grant_idx is done in the top level from the registered index.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=8'hFF, then req=8'h00 → grant=0, grant_idx=0, grant_valid=0, preempt=0 throughout.
- Basic + handoff: after reset, req=8'b0000_0101 →
  - next cycle: grant=8'h01, idx=0.
  - drop req[0] → next cycle: grant=8'h04, idx=2, no zero cycle.
  - drop req[2] → next cycle: grant=0.
- Wrap-around: holder idx=7 releases with req=8'h03 → next grant=8'h01 (idx 0), not idx 1; later with req=8'h03, requester 1 is served before 0.
- Preemption (MAX_HOLD=4): req[3] and req[5] held high →
  - grant=8'h08 for 4 cycles.
  - then grant=8'h20 with preempt=1 for that single cycle.
  - after 4 more cycles, back to 8'h08.
- Sole requester timeout (MAX_HOLD=4): req=8'h80 held → grant stays 8'h80 continuously; preempt pulses once every 4 cycles.
- Enable and reset mid-grant:
  - en=0 with req=8'h10 from idle → no grant.
  - en=1 → grant=8'h10 next cycle.
  - rst=1 while granted → all outputs 0 next cycle; after rst release, ptr=0 so req=8'h11 grants idx 0.
